// File: rtl/lifo_pkg.sv
// Shared definitions for the button-driven LIFO controller: FSM encoding and
// default sizing.
package lifo_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUSH   = 3'd1,
    S_POP_RD = 3'd2,
    S_POP_WT = 3'd3,
    S_TOP_RD = 3'd4,
    S_TOP_WT = 3'd5,
    S_CLR    = 3'd6
  } state_e;

endpackage

// File: rtl/lifo_req_arb.sv
// Holds button requests that arrive while the controller is busy and grants
// one of them per IDLE cycle, clear first, then pop, then push.
module lifo_req_arb #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          push_pls,
  input  logic          pop_pls,
  input  logic          clr_pls,
  input  logic [DW-1:0] din,
  input  logic          grant_en,
  input  logic          discard,
  output logic          gnt_clr,
  output logic          gnt_pop,
  output logic          gnt_push,
  output logic [DW-1:0] push_data
);

  logic          pclr, ppop, ppush;
  logic [DW-1:0] dlat;
  logic          req_clr, req_pop, req_push;

  // A pulse in the grant cycle competes alongside the held flags.
  assign req_clr  = pclr  | clr_pls;
  assign req_pop  = ppop  | pop_pls;
  assign req_push = ppush | push_pls;

  assign gnt_clr   = grant_en & req_clr;
  assign gnt_pop   = grant_en & ~req_clr & req_pop;
  assign gnt_push  = grant_en & ~req_clr & ~req_pop & req_push;
  assign push_data = ppush ? dlat : din;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pclr  <= 1'b0;
      ppop  <= 1'b0;
      ppush <= 1'b0;
      dlat  <= '0;
    end else begin
      pclr  <= req_clr & ~gnt_clr;
      ppop  <= req_pop & ~gnt_pop & ~discard;
      ppush <= req_push & ~gnt_push & ~discard;
      if (push_pls && !ppush)
        dlat <= din;
    end
  end

endmodule

// File: rtl/lifo_btn_ctrl.sv
// Sequences push/pop/clear button requests onto a single-port synchronous
// stack RAM, tracking the stack pointer, top-of-stack and popped value.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting; arbitrates held requests, rejects pop when empty
// PUSH     | write cycle (suppressed and flagged when full)
// POP_RD   | read of the top entry issued
// POP_WT   | popped data captured, pointer decremented
// TOP_RD   | read of the new top entry issued
// TOP_WT   | new top captured
// CLR      | pointer and top cleared, pending push/pop dropped
module lifo_btn_ctrl
  import lifo_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clr,
  input  logic [DW-1:0] i_data,
  output logic          o_we,
  output logic          o_re,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  input  logic [DW-1:0] i_rdata,
  output logic [DW-1:0] o_top,
  output logic [DW-1:0] o_dout,
  output logic          o_dout_vld,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_err,
  output logic          o_busy
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] SP_ONE   = (AW+1)'(1);

  state_e        state, state_nx;
  logic [AW:0]   sp, sp_nx;
  logic          pop_err_q, pop_err_nx;
  logic          grant_en, discard;
  logic          gnt_clr, gnt_pop, gnt_push;
  logic [DW-1:0] push_data;

  logic          we_nx, re_nx, vld_nx, err_nx;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] wdata_nx, top_nx, dout_nx;

  lifo_req_arb #(.DW(DW)) u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push_pls  (i_push),
    .pop_pls   (i_pop),
    .clr_pls   (i_clr),
    .din       (i_data),
    .grant_en  (grant_en),
    .discard   (discard),
    .gnt_clr   (gnt_clr),
    .gnt_pop   (gnt_pop),
    .gnt_push  (gnt_push),
    .push_data (push_data)
  );

  assign o_count = sp;

  // Next values for every output register are decided here, so the RAM
  // strobes go high on the very edge that leaves IDLE.
  always_comb begin
    state_nx   = state;
    sp_nx      = sp;
    pop_err_nx = 1'b0;
    grant_en   = 1'b0;
    discard    = 1'b0;
    we_nx      = 1'b0;
    re_nx      = 1'b0;
    vld_nx     = 1'b0;
    err_nx     = pop_err_q;
    addr_nx    = o_addr;
    wdata_nx   = o_wdata;
    top_nx     = o_top;
    dout_nx    = o_dout;

    case (state)
      S_IDLE: begin
        grant_en = 1'b1;
        if (gnt_clr) begin
          state_nx = S_CLR;
        end else if (gnt_pop) begin
          if (sp == '0) begin
            pop_err_nx = 1'b1;
          end else begin
            state_nx = S_POP_RD;
            re_nx    = 1'b1;
            addr_nx  = sp[AW-1:0] - AW'(1);
          end
        end else if (gnt_push) begin
          state_nx = S_PUSH;
          if (sp != FULL_CNT) begin
            we_nx    = 1'b1;
            addr_nx  = sp[AW-1:0];
            wdata_nx = push_data;
          end
        end
      end
      S_PUSH: begin
        state_nx = S_IDLE;
        if (sp == FULL_CNT) begin
          err_nx = 1'b1;
        end else begin
          sp_nx  = sp + SP_ONE;
          top_nx = o_wdata;
        end
      end
      S_POP_RD: state_nx = S_POP_WT;
      S_POP_WT: begin
        dout_nx = i_rdata;
        vld_nx  = 1'b1;
        sp_nx   = sp - SP_ONE;
        if (sp > SP_ONE) begin
          state_nx = S_TOP_RD;
          re_nx    = 1'b1;
          addr_nx  = sp[AW-1:0] - AW'(2);
        end else begin
          state_nx = S_IDLE;
          top_nx   = '0;
        end
      end
      S_TOP_RD: state_nx = S_TOP_WT;
      S_TOP_WT: begin
        top_nx   = i_rdata;
        state_nx = S_IDLE;
      end
      S_CLR: begin
        discard  = 1'b1;
        sp_nx    = '0;
        top_nx   = '0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      sp         <= '0;
      pop_err_q  <= 1'b0;
      o_we       <= 1'b0;
      o_re       <= 1'b0;
      o_addr     <= '0;
      o_wdata    <= '0;
      o_top      <= '0;
      o_dout     <= '0;
      o_dout_vld <= 1'b0;
      o_full     <= 1'b0;
      o_empty    <= 1'b1;
      o_err      <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nx;
      sp         <= sp_nx;
      pop_err_q  <= pop_err_nx;
      o_we       <= we_nx;
      o_re       <= re_nx;
      o_addr     <= addr_nx;
      o_wdata    <= wdata_nx;
      o_top      <= top_nx;
      o_dout     <= dout_nx;
      o_dout_vld <= vld_nx;
      o_full     <= (sp_nx == FULL_CNT);
      o_empty    <= (sp_nx == '0);
      o_err      <= err_nx;
      o_busy     <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_lifo_btn_ctrl.sv
// Directed bench for lifo_btn_ctrl with a 4-entry stack and a behavioural
// single-port RAM attached.
module tb_lifo_btn_ctrl;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_push, i_pop, i_clr;
  logic [DW-1:0] i_data;
  logic [DW-1:0] i_rdata;
  logic          o_we, o_re, o_dout_vld, o_full, o_empty, o_err, o_busy;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata, o_top, o_dout;
  logic [AW:0]   o_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [DEPTH];

  lifo_btn_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (i_push),
    .i_pop      (i_pop),
    .i_clr      (i_clr),
    .i_data     (i_data),
    .o_we       (o_we),
    .o_re       (o_re),
    .o_addr     (o_addr),
    .o_wdata    (o_wdata),
    .i_rdata    (i_rdata),
    .o_top      (o_top),
    .o_dout     (o_dout),
    .o_dout_vld (o_dout_vld),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_err      (o_err),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_we) mem[o_addr] <= o_wdata;
    if (o_re) i_rdata <= mem[o_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    chk("we_re_excl", 32'(o_we & o_re), 0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] exp_addr);
    i_data = d;
    i_push = 1'b1;
    step();
    i_push = 1'b0;
    chk("push_we", 32'(o_we), 1);
    chk("push_addr", 32'(o_addr), 32'(exp_addr));
    chk("push_wdata", 32'(o_wdata), 32'(d));
    step();
    chk("push_top", 32'(o_top), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst_n = 1'b0;
    i_push = 1'b0;
    i_pop = 1'b0;
    i_clr = 1'b0;
    i_data = '0;
    #12;
    chk("rst_we", 32'(o_we), 0);
    chk("rst_re", 32'(o_re), 0);
    chk("rst_addr", 32'(o_addr), 0);
    chk("rst_top", 32'(o_top), 0);
    chk("rst_dout", 32'(o_dout), 0);
    chk("rst_vld", 32'(o_dout_vld), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_empty", 32'(o_empty), 1);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_busy", 32'(o_busy), 0);
    do_reset();

    // three pushes
    push(8'h11, 2'd0);
    push(8'h22, 2'd1);
    push(8'h33, 2'd2);
    chk("p3_count", 32'(o_count), 3);
    chk("p3_empty", 32'(o_empty), 0);
    chk("p3_full", 32'(o_full), 0);

    // pop with refill of top
    i_pop = 1'b1;
    step();
    i_pop = 1'b0;
    chk("pop_g_re", 32'(o_re), 1);
    chk("pop_g_addr", 32'(o_addr), 2);
    chk("pop_g_busy", 32'(o_busy), 1);
    step();
    chk("pop_g1_re", 32'(o_re), 0);
    chk("pop_g1_vld", 32'(o_dout_vld), 0);
    step();
    chk("pop_g2_vld", 32'(o_dout_vld), 1);
    chk("pop_g2_dout", 32'(o_dout), 32'h33);
    chk("pop_g2_count", 32'(o_count), 2);
    chk("pop_g2_re", 32'(o_re), 1);
    chk("pop_g2_addr", 32'(o_addr), 1);
    step();
    chk("pop_g3_vld", 32'(o_dout_vld), 0);
    chk("pop_g3_top", 32'(o_top), 32'h33);
    step();
    chk("pop_g4_top", 32'(o_top), 32'h22);
    chk("pop_g4_busy", 32'(o_busy), 0);

    // fill to full, then overflow push
    push(8'h44, 2'd2);
    push(8'h55, 2'd3);
    chk("full_flag", 32'(o_full), 1);
    chk("full_count", 32'(o_count), 4);
    i_data = 8'h66;
    i_push = 1'b1;
    step();
    i_push = 1'b0;
    chk("ovf_we", 32'(o_we), 0);
    chk("ovf_busy", 32'(o_busy), 1);
    step();
    chk("ovf_err", 32'(o_err), 1);
    chk("ovf_top", 32'(o_top), 32'h55);
    chk("ovf_count", 32'(o_count), 4);
    chk("ovf_full", 32'(o_full), 1);
    step();
    chk("ovf_err_off", 32'(o_err), 0);

    // pop on empty after reset
    do_reset();
    i_pop = 1'b1;
    step();
    i_pop = 1'b0;
    chk("udf_g_re", 32'(o_re), 0);
    chk("udf_g_busy", 32'(o_busy), 0);
    step();
    chk("udf_err", 32'(o_err), 1);
    chk("udf_vld", 32'(o_dout_vld), 0);
    step();
    chk("udf_err_off", 32'(o_err), 0);
    chk("udf_count", 32'(o_count), 0);
    chk("udf_top", 32'(o_top), 0);
    chk("udf_vld2", 32'(o_dout_vld), 0);

    // requests while busy: push in POP_WT, clear+pop in TOP_RD
    push(8'hA1, 2'd0);
    push(8'hB2, 2'd1);
    i_pop = 1'b1;
    step();
    i_pop = 1'b0;
    step();
    i_data = 8'hAA;
    i_push = 1'b1;
    step();
    i_push = 1'b0;
    chk("arb_dout", 32'(o_dout), 32'hB2);
    chk("arb_vld", 32'(o_dout_vld), 1);
    i_clr = 1'b1;
    i_pop = 1'b1;
    step();
    i_clr = 1'b0;
    i_pop = 1'b0;
    step();
    chk("arb_top", 32'(o_top), 32'hA1);
    chk("arb_count1", 32'(o_count), 1);
    step();
    chk("arb_clr_busy", 32'(o_busy), 1);
    chk("arb_clr_we", 32'(o_we), 0);
    chk("arb_clr_re", 32'(o_re), 0);
    step();
    chk("arb_count0", 32'(o_count), 0);
    chk("arb_empty", 32'(o_empty), 1);
    chk("arb_top0", 32'(o_top), 0);
    chk("arb_dout_keep", 32'(o_dout), 32'hB2);
    step();
    chk("arb_idle_busy", 32'(o_busy), 0);
    chk("arb_idle_we", 32'(o_we), 0);
    chk("arb_idle_re", 32'(o_re), 0);
    step();
    chk("arb_idle_count", 32'(o_count), 0);
    chk("arb_idle_err", 32'(o_err), 0);

    // asynchronous reset during TOP_RD
    push(8'h10, 2'd0);
    push(8'h20, 2'd1);
    i_pop = 1'b1;
    step();
    i_pop = 1'b0;
    step();
    step();
    chk("ar_toprd_re", 32'(o_re), 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("ar_re", 32'(o_re), 0);
    chk("ar_count", 32'(o_count), 0);
    chk("ar_empty", 32'(o_empty), 1);
    chk("ar_busy", 32'(o_busy), 0);
    chk("ar_dout", 32'(o_dout), 0);
    chk("ar_vld", 32'(o_dout_vld), 0);
    chk("ar_top", 32'(o_top), 0);
    #3;
    i_rst_n = 1'b1;
    push(8'h5A, 2'd0);
    chk("ar_push_count", 32'(o_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
